cart_rom_arbiter: RTL and testbench
===================================

// Module: cart_rom_arbiter
// PURPOSE
//  Shares one single-port cartridge ROM image (iNES byte layout: header, PRG, CHR) between CPU PRG reads
//  and PPU CHR reads. Maps bus addresses to flat file offsets, including PRG mirroring. Arbitrates
//  round-robin and runs one read at a time against a fixed-latency memory. Sits between the CPU/PPU
//  address buses and the ROM storage, replacing direct per-bus ROM ports.
// PARAMETERS
//  HDR_OFS    16       byte offset of PRG data in image (iNES header size)
//  PRG_SIZE   16384    PRG bytes, power of 2; CPU $8000-$FFFF mirrors modulo PRG_SIZE
//  CHR_SIZE   8192     CHR bytes, power of 2; placed at HDR_OFS+PRG_SIZE
//  ADDR_W     16       mem_addr width
//  RD_LAT     2        cycles from mem_rd to mem_rdata valid, >=1
//  UNMAP_D    8'hFF    data returned for unmapped addresses
// PORTS
//  clk        in   1       single clock, all logic rising-edge
//  rst_n      in   1       asynchronous active-low reset
//  cpu_req    in   1       CPU read request, level, held until cpu_ack
//  cpu_ab     in   16      CPU address, stable while cpu_req
//  cpu_ack    out  1       one-cycle pulse, cpu_do valid
//  cpu_do     out  8       read data, held until next cpu_ack
//  ppu_req    in   1       PPU read request, level, held until ppu_ack
//  ppu_ab     in   16      PPU address, stable while ppu_req
//  ppu_ack    out  1       one-cycle pulse, ppu_do valid
//  ppu_do     out  8       read data, held until next ppu_ack
//  mem_rd     out  1       one-cycle read strobe to ROM storage
//  mem_addr   out  ADDR_W  flat image byte offset, valid while mem_rd
//  mem_rdata  in   8       ROM data, valid RD_LAT cycles after mem_rd
//  busy       out  1       high in any state other than IDLE
// BEHAVIOUR
//  Reset: all outputs 0 (cpu_do/ppu_do=8'h00); state=IDLE; last_grant=PPU; latency counter=0.
//  Address map:
//   - CPU, cpu_ab[15]=1: HDR_OFS + (cpu_ab & (PRG_SIZE-1)).
//   - PPU, ppu_ab<CHR_SIZE: HDR_OFS + PRG_SIZE + ppu_ab.
//   - All other addresses are unmapped: no mem_rd is issued; data=UNMAP_D.
//  FSM:
//   - IDLE: sample reqs. If none, stay. If both, grant the requester != last_grant.
//     Latch grant, address and data path, then update last_grant.
//     Mapped -> ISSUE. Unmapped -> RESP with data=UNMAP_D.
//   - ISSUE (1 cycle): mem_rd=1, mem_addr=mapped offset. Load counter=RD_LAT-1 -> WAIT.
//   - WAIT: decrement counter. When counter==0, capture mem_rdata at this edge -> RESP.
//   - RESP (1 cycle): granted ack=1 with the captured data on its _do port -> IDLE.
//  Latency:
//   - req seen in IDLE at cycle 0 -> mem_rd at cycle 1 -> ack at cycle RD_LAT+2.
//   - Unmapped: ack at cycle 1.
//  Throughput: one mapped read per RD_LAT+3 cycles. Only one access is ever outstanding.
//  Handshake: requester drops req the cycle after ack. A req high in the IDLE cycle after RESP
//   is a new request. A req that drops before ack is a protocol error; the read still completes
//   and acks.
//  Simultaneous events:
//   - A req arriving during ISSUE/WAIT/RESP waits; it is never lost.
//   - Alternating grants under continuous contention: no requester waits more than one transaction.
//  mem_addr holds its last value when mem_rd=0. Counter width is $clog2(RD_LAT+1).
//  rst_n low mid-transaction: immediate abort. No ack is generated for the aborted read.
//   After release, start in IDLE with last_grant=PPU.
// TESTING
//  - Reset vector, RD_LAT=2: cpu_ab=$FFFC req -> mem_addr=16'h400C, mem_rd at cyc1, cpu_ack at cyc4,
//    cpu_do=8'h04. cpu_ab=$FFFD -> 8'hC0.
//  - Mirror: cpu_ab=$C004 and cpu_ab=$8004 -> both mem_addr=16'h0014, cpu_do=8'h78.
//  - CHR sweep: ppu_ab=0..63 -> mem_addr=ppu_ab+16'h4010, ppu_do equals image byte, one ppu_ack each.
//  - Contention: cpu_req and ppu_req held continuously from reset.
//    -> grant order CPU,PPU,CPU,PPU...; acks spaced 5 cycles; no double ack.
//  - Unmapped: cpu_ab=$2002 and ppu_ab=$3F00 -> ack at cyc1, data 8'hFF, mem_rd never asserted.
//  - rst_n pulsed low during WAIT -> all outputs 0 immediately, no ack for that read.
//    Re-issued request then completes normally.

Source files
------------

// File: rtl/cart_rom_arbiter.sv
// Round-robin arbiter sharing one fixed-latency cartridge ROM image between CPU PRG and PPU CHR reads.
// Bus addresses are mapped to flat iNES file offsets; unmapped reads are answered locally.
module cart_rom_arbiter #(
   parameter int          HDR_OFS  = 16,
   parameter int          PRG_SIZE = 16384,
   parameter int          CHR_SIZE = 8192,
   parameter int          ADDR_W   = 16,
   parameter int          RD_LAT   = 2,
   parameter logic [7:0]  UNMAP_D  = 8'hFF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cpu_req,
   input  logic [15:0]       cpu_ab,
   output logic              cpu_ack,
   output logic [7:0]        cpu_do,
   input  logic              ppu_req,
   input  logic [15:0]       ppu_ab,
   output logic              ppu_ack,
   output logic [7:0]        ppu_do,
   output logic              mem_rd,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [7:0]        mem_rdata,
   output logic              busy
);

   localparam int CNT_W = $clog2(RD_LAT + 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic               last_cpu;
   logic               grant_cpu;

   logic               cpu_map;
   logic               ppu_map;
   logic               pick_cpu;
   logic               pick_map;
   logic [ADDR_W-1:0]  cpu_off;
   logic [ADDR_W-1:0]  ppu_off;
   logic [ADDR_W-1:0]  pick_off;

   // PRG mirrors across $8000-$FFFF; CHR sits directly after PRG in the image.
   assign cpu_map  = cpu_ab[15];
   assign ppu_map  = 32'(ppu_ab) < CHR_SIZE;
   assign cpu_off  = ADDR_W'(HDR_OFS) + ADDR_W'(cpu_ab & 16'(PRG_SIZE - 1));
   assign ppu_off  = ADDR_W'(HDR_OFS + PRG_SIZE) + ADDR_W'(ppu_ab);

   // Under contention the requester that was not served last wins.
   assign pick_cpu = cpu_req && (!ppu_req || !last_cpu);
   assign pick_map = pick_cpu ? cpu_map : ppu_map;
   assign pick_off = pick_cpu ? cpu_off : ppu_off;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         last_cpu  <= 1'b0;
         grant_cpu <= 1'b0;
         cpu_ack   <= 1'b0;
         cpu_do    <= 8'h00;
         ppu_ack   <= 1'b0;
         ppu_do    <= 8'h00;
         mem_rd    <= 1'b0;
         mem_addr  <= '0;
         busy      <= 1'b0;
      end else begin
         mem_rd  <= 1'b0;
         cpu_ack <= 1'b0;
         ppu_ack <= 1'b0;
         case (state)
            IDLE: begin
               if (cpu_req || ppu_req) begin
                  grant_cpu <= pick_cpu;
                  last_cpu  <= pick_cpu;
                  busy      <= 1'b1;
                  if (pick_map) begin
                     state    <= ISSUE;
                     mem_rd   <= 1'b1;
                     mem_addr <= pick_off;
                  end else begin
                     // Unmapped reads never touch the ROM and answer on the next cycle.
                     state <= RESP;
                     if (pick_cpu) begin
                        cpu_ack <= 1'b1;
                        cpu_do  <= UNMAP_D;
                     end else begin
                        ppu_ack <= 1'b1;
                        ppu_do  <= UNMAP_D;
                     end
                  end
               end
            end
            ISSUE: begin
               cnt   <= CNT_W'(RD_LAT - 1);
               state <= WAIT;
            end
            WAIT: begin
               if (cnt == '0) begin
                  state <= RESP;
                  if (grant_cpu) begin
                     cpu_ack <= 1'b1;
                     cpu_do  <= mem_rdata;
                  end else begin
                     ppu_ack <= 1'b1;
                     ppu_do  <= mem_rdata;
                  end
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            RESP: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cart_rom_arbiter.sv
// Bench for cart_rom_arbiter: transaction-level timing model checked every cycle, directed
// literal cases (reset vector, mirroring, CHR sweep, unmapped, abort, contention) and random traffic.
module tb_cart_rom_arbiter;

   localparam int RD_LAT = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cpu_req = 1'b0;
   logic [15:0] cpu_ab = 16'h0;
   logic        cpu_ack;
   logic [7:0]  cpu_do;
   logic        ppu_req = 1'b0;
   logic [15:0] ppu_ab = 16'h0;
   logic        ppu_ack;
   logic [7:0]  ppu_do;
   logic        mem_rd;
   logic [15:0] mem_addr;
   logic [7:0]  mem_rdata;
   logic        busy;

   logic [7:0]  image [0:65535];

   int checks = 0;
   int passed = 0;

   always #5 clk = ~clk;

   cart_rom_arbiter #(
      .HDR_OFS(16), .PRG_SIZE(16384), .CHR_SIZE(8192),
      .ADDR_W(16), .RD_LAT(RD_LAT), .UNMAP_D(8'hFF)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .cpu_req(cpu_req), .cpu_ab(cpu_ab), .cpu_ack(cpu_ack), .cpu_do(cpu_do),
      .ppu_req(ppu_req), .ppu_ab(ppu_ab), .ppu_ack(ppu_ack), .ppu_do(ppu_do),
      .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .busy(busy)
   );

   // ROM storage: data for a strobe appears RD_LAT cycles later, garbage otherwise.
   logic [RD_LAT-1:0] vpipe = '0;
   logic [15:0]       apipe [RD_LAT];
   logic [7:0]        junk = 8'h00;

   always @(posedge clk) begin
      vpipe[0] <= mem_rd;
      apipe[0] <= mem_addr;
      for (int i = 1; i < RD_LAT; i++) begin
         vpipe[i] <= vpipe[i-1];
         apipe[i] <= apipe[i-1];
      end
      junk <= 8'($urandom);
   end

   assign mem_rdata = vpipe[RD_LAT-1] ? image[apipe[RD_LAT-1]] : junk;

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   // Transaction model: each grant fixes the cycles of its strobe and ack and the data returned.
   int          m_cyc, m_rd_at, m_ack_at, m_grant_at, m_ofs;
   bit          m_last_cpu, m_grant_cpu, m_pick_cpu, m_mapped, m_busy;
   logic [15:0] m_addr, m_pend_addr;
   logic [7:0]  m_cpu_do, m_ppu_do, m_data;

   always @(negedge clk) begin
      if (!rst_n) begin
         m_cyc = 0; m_rd_at = -1; m_ack_at = -1; m_grant_at = -1;
         m_last_cpu = 1'b0; m_grant_cpu = 1'b0;
         m_addr = 16'h0; m_cpu_do = 8'h00; m_ppu_do = 8'h00;
         check_output("reset_ctl", {busy, mem_rd, cpu_ack, ppu_ack}, 0);
         check_output("reset_data", {mem_addr, cpu_do, ppu_do}, 0);
      end else begin
         m_cyc++;
         if (m_cyc == m_rd_at) m_addr = m_pend_addr;
         if (m_cyc == m_ack_at) begin
            if (m_grant_cpu) m_cpu_do = m_data;
            else m_ppu_do = m_data;
         end
         m_busy = (m_ack_at >= 0) && (m_cyc > m_grant_at) && (m_cyc <= m_ack_at);
         check_output("model_ctl", {busy, mem_rd, cpu_ack, ppu_ack},
                      {m_busy, m_cyc == m_rd_at, m_cyc == m_ack_at && m_grant_cpu,
                       m_cyc == m_ack_at && !m_grant_cpu});
         check_output("model_mem_addr", mem_addr, m_addr);
         check_output("model_cpu_do", cpu_do, m_cpu_do);
         check_output("model_ppu_do", ppu_do, m_ppu_do);
         if ((m_ack_at < 0 || m_cyc > m_ack_at) && (cpu_req || ppu_req)) begin
            if (cpu_req && ppu_req) m_pick_cpu = !m_last_cpu;
            else m_pick_cpu = cpu_req;
            m_grant_cpu = m_pick_cpu;
            m_last_cpu  = m_pick_cpu;
            m_grant_at  = m_cyc;
            if (m_pick_cpu) begin
               m_mapped = cpu_ab >= 16'h8000;
               m_ofs    = 16 + (int'(cpu_ab) % 16384);
            end else begin
               m_mapped = ppu_ab < 16'd8192;
               m_ofs    = 16 + 16384 + int'(ppu_ab);
            end
            if (m_mapped) begin
               m_pend_addr = 16'(m_ofs);
               m_rd_at     = m_cyc + 1;
               m_ack_at    = m_cyc + RD_LAT + 2;
               m_data      = image[16'(m_ofs)];
            end else begin
               m_rd_at  = -1;
               m_ack_at = m_cyc + 1;
               m_data   = 8'hFF;
            end
         end
      end
   end

   // One isolated read with literal expectations; starts and ends with the arbiter idle.
   task automatic apply_stimulus(input bit is_cpu, input logic [15:0] ab, input logic [7:0] exp_data,
                                 input int exp_lat, input bit exp_rd, input logic [15:0] exp_addr,
                                 input string name);
      int          n;
      bit          got, saw_rd;
      logic [15:0] rd_addr;
      logic [7:0]  data;
      n = 0; got = 0; saw_rd = 0; rd_addr = 16'h0; data = 8'h00;
      if (is_cpu) begin cpu_req = 1'b1; cpu_ab = ab; end
      else begin ppu_req = 1'b1; ppu_ab = ab; end
      while (!got && n < 50) begin
         @(posedge clk); #1;
         n++;
         if (mem_rd) begin saw_rd = 1'b1; rd_addr = mem_addr; end
         if (is_cpu ? cpu_ack : ppu_ack) begin
            got  = 1'b1;
            data = is_cpu ? cpu_do : ppu_do;
         end
      end
      cpu_req = 1'b0;
      ppu_req = 1'b0;
      check_output({name, "_ack"}, got, 1);
      check_output({name, "_latency"}, n, exp_lat);
      check_output({name, "_data"}, data, exp_data);
      check_output({name, "_mem_rd"}, saw_rd, exp_rd);
      if (exp_rd) check_output({name, "_mem_addr"}, rd_addr, exp_addr);
      @(posedge clk); #1;
   endtask

   int n_ack, k;

   initial begin
      for (int i = 0; i < 65536; i++) image[i] = 8'($urandom);
      image[16'h400C] = 8'h04;
      image[16'h400D] = 8'hC0;
      image[16'h0014] = 8'h78;

      repeat (3) @(posedge clk);
      #1;
      check_output("init_ctl", {busy, mem_rd, cpu_ack, ppu_ack}, 0);
      check_output("init_data", {mem_addr, cpu_do, ppu_do}, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      apply_stimulus(1'b1, 16'hFFFC, 8'h04, 4, 1'b1, 16'h400C, "vec_lo");
      apply_stimulus(1'b1, 16'hFFFD, 8'hC0, 4, 1'b1, 16'h400D, "vec_hi");
      apply_stimulus(1'b1, 16'hC004, 8'h78, 4, 1'b1, 16'h0014, "mirror_c004");
      apply_stimulus(1'b1, 16'h8004, 8'h78, 4, 1'b1, 16'h0014, "mirror_8004");
      for (int i = 0; i < 64; i++)
         apply_stimulus(1'b0, 16'(i), image[16'h4010 + 16'(i)], 4, 1'b1, 16'h4010 + 16'(i), "chr");
      apply_stimulus(1'b1, 16'h2002, 8'hFF, 1, 1'b0, 16'h0, "unmap_cpu");
      apply_stimulus(1'b0, 16'h3F00, 8'hFF, 1, 1'b0, 16'h0, "unmap_ppu");

      // Abort a read while it waits on the ROM.
      cpu_req = 1'b1; cpu_ab = 16'hFFFC;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      check_output("abort_ctl", {busy, mem_rd, cpu_ack, ppu_ack}, 0);
      check_output("abort_data", {mem_addr, cpu_do, ppu_do}, 0);
      cpu_req = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      n_ack = 0;
      repeat (8) begin
         @(posedge clk); #1;
         if (cpu_ack || ppu_ack) n_ack++;
      end
      check_output("abort_no_ack", n_ack, 0);
      apply_stimulus(1'b1, 16'hFFFC, 8'h04, 4, 1'b1, 16'h400C, "reissue");

      // Both requesters held from reset: CPU first, strict alternation, one ack per 5 cycles.
      rst_n = 1'b0;
      cpu_req = 1'b1; cpu_ab = 16'h8004;
      ppu_req = 1'b1; ppu_ab = 16'h0000;
      @(posedge clk); #1;
      rst_n = 1'b1;
      k = 0;
      for (int c = 1; c <= 40; c++) begin
         @(posedge clk); #1;
         if (cpu_ack || ppu_ack) begin
            check_output("cont_single_ack", {cpu_ack, ppu_ack} == 2'b11, 0);
            check_output("cont_cycle", c, 4 + 5 * k);
            check_output("cont_cpu_turn", cpu_ack, (k % 2) == 0);
            if (cpu_ack) check_output("cont_cpu_do", cpu_do, 8'h78);
            else check_output("cont_ppu_do", ppu_do, image[16'h4010]);
            k++;
         end
      end
      cpu_req = 1'b0;
      ppu_req = 1'b0;
      check_output("cont_count", k, 8);
      repeat (3) @(posedge clk);
      #1;

      // Random traffic; each requester holds its address until acked.
      for (int c = 0; c < 3000; c++) begin
         @(posedge clk); #1;
         if (cpu_req && cpu_ack) cpu_req = 1'b0;
         else if (!cpu_req && $urandom_range(0, 2) == 0) begin
            cpu_req = 1'b1;
            cpu_ab  = 16'($urandom_range(0, 65535));
         end
         if (ppu_req && ppu_ack) ppu_req = 1'b0;
         else if (!ppu_req && $urandom_range(0, 2) == 0) begin
            ppu_req = 1'b1;
            ppu_ab  = 16'($urandom_range(0, 16383));
         end
      end
      cpu_req = 1'b0;
      ppu_req = 1'b0;
      repeat (10) @(posedge clk);
      #1;

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
